uart_tx_packetizer: RTL
=======================

# uart_tx_packetizer

Store-and-forward framer sitting directly upstream of the UART transmitter. It buffers one payload of up to `DEPTH` bytes from a byte-stream source and then emits a framed packet on a valid/ready byte interface wired straight to the transmitter's `data_in`/`data_in_valid`/`data_in_ready`. The frame is a sync byte, a length byte, the payload, and an optional checksum, so the host-side parser can resynchronise on the serial link.

## Interface
- `DEPTH`, 16: payload buffer size in bytes; power of two, 2..128.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  qualifies `in_data` as the final payload byte.
- `in_ready`  out  1  block accepts a payload byte this cycle.
- `out_data`  out  8  frame byte to the transmitter.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  transmitter accepts the byte.
- `busy`  out  1  frame being emitted, i.e. not in COLLECT.
- `trunc`  out  1  one-cycle pulse: payload auto-terminated at `DEPTH` bytes.

## Operation
- States:
  - COLLECT: reset state.
  - SYNC, LEN, PAYLOAD: frame emission.
  - CHK: present only with the macro defined.
- COLLECT:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, write `in_data` to `buf[wr_ptr]`, then `wr_ptr++` and `cnt++`.
  - If `in_last`, or if the accepted byte is the `DEPTH`-th byte, go to SYNC.
  - In the `DEPTH` case, if `in_last`=0, `trunc` pulses on the next cycle, and subsequent bytes start a new packet.
- SYNC: present `SYNC_BYTE`. On handshake, go to LEN.
- LEN: present `cnt` (1..`DEPTH`). On handshake, go to PAYLOAD with `rd_ptr`=0.
- PAYLOAD:
  - Present `buf[rd_ptr]`; `rd_ptr++` on each handshake.
  - After byte `cnt-1` is accepted, go to CHK (macro defined) or COLLECT (macro undefined).
- CHK: present the checksum. On handshake, go to COLLECT.
- Returning to COLLECT clears `cnt`, `wr_ptr` and `rd_ptr`.
- In every state other than COLLECT, `in_ready`=0. Only one packet is buffered at a time.
- Arithmetic:
  - `cnt` is $clog2(`DEPTH`)+1 bits, zero-extended to 8 bits for LEN.
  - Checksum accumulator is 8 bits and wraps mod 256.
- Zero-length packets are impossible: a packet always contains at least the byte carrying `in_last`.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=8'h00, `in_ready`=1, `busy`=0, `trunc`=0.
  - State=COLLECT; all counters=0.
  - Buffer contents are don't-care.
- `out_data` and `out_valid` are registered.
- Latency: SYNC is valid on the cycle after the last payload byte is accepted.
- Handshake:
  - A byte transfers on any cycle with `out_valid&&out_ready`.
  - While `out_valid`=1 and `out_ready`=0, `out_data` is held stable.
  - `out_valid` never drops without a handshake.
- Back-to-back: the next frame byte is valid on the cycle after a handshake, so there is no bubble when `out_ready` is held high.
- `in_ready` rises on the cycle after the final frame byte is accepted.
- `rst` asserted mid-frame or mid-collect: the frame is aborted at the next edge, outputs take reset values, and no partial frame is resumed.
- `in_valid` while `in_ready`=0: ignored, with no effect on state.

## Configuration
- `UART_TX_PKT_CHECKSUM_EN`:
  - Defined: CHK state is compiled in. After the payload, the block emits CHK = (−(LEN + Σpayload)) mod 256, so LEN + payload + CHK ≡ 0 mod 256. The accumulator updates on each LEN/PAYLOAD handshake.
  - Undefined: no accumulator and no CHK state. Frame length is `cnt`+2 bytes.

## Test plan
- Macro defined, `out_ready`=1, payload 01 02 03 with `in_last` on 03 -> `out_data` sequence A5 03 01 02 03 F7 on consecutive cycles; `in_ready` returns to 1 after F7.
- Macro undefined, same stimulus -> A5 03 01 02 03; `busy` high for exactly 5 handshakes.
- `DEPTH`=16, 18 bytes 00..11 with `in_last` only on 11 -> `trunc` pulses once; frame 1 is A5 10 00..0F; frame 2 is A5 02 10 11 (plus CHK DD when the macro is defined).
- Backpressure: `out_ready` toggled randomly at 50% during a payload of 1 byte, AA -> `out_data` stable while stalled; sequence A5 01 AA 55 (macro defined).
- `rst` pulsed during PAYLOAD of an 8-byte packet -> next cycle `out_valid`=0, `in_ready`=1; a new 1-byte packet 7E yields A5 01 7E 81.
- `in_valid`=1 held during emission -> no bytes accepted until `in_ready`=1; the held byte is then the first byte of the next packet.

Source files
------------

// File: rtl/uart_tx_packetizer_if.sv
// uart_tx_packetizer_if: payload byte stream in, framed byte stream out, plus status.
interface uart_tx_packetizer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       trunc;
  modport master (output in_data, in_valid, in_last, out_ready,
                  input  in_ready, out_data, out_valid, busy, trunc);
  modport slave  (input  in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_valid, busy, trunc);
endinterface

// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: buffers one payload, emits SYNC/LEN/payload frame; UART_TX_PKT_CHECKSUM_EN appends CHK.
module uart_tx_packetizer #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic rst,
  uart_tx_packetizer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {
    COLLECT, SYNC, LEN, PAYLOAD
`ifdef UART_TX_PKT_CHECKSUM_EN
    , CHK
`endif
  } state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [7:0] odata, odata_n;
  logic ovalid, ovalid_n, trunc_q;
  logic hs, accept, full, last_rd;
  assign hs = ovalid && bus.out_ready;
  assign accept = state == COLLECT && bus.in_valid;
  assign full = cnt == CW'(DEPTH - 1);
  assign last_rd = rd_ptr == AW'(cnt - CW'(1));
`ifdef UART_TX_PKT_CHECKSUM_EN
  logic [7:0] acc;
  always_ff @(posedge clk)
    if (rst || state == COLLECT) acc <= '0;
    else if (hs && (state == LEN || state == PAYLOAD)) acc <= acc + odata;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rd_ptr_n = rd_ptr;
    odata_n = odata;
    ovalid_n = ovalid;
    case (state)
      COLLECT: if (accept) begin
        cnt_n = cnt + 1'b1;
        if (bus.in_last || full) begin
          state_n = SYNC;
          odata_n = SYNC_BYTE;
          ovalid_n = 1'b1;
        end
      end
      SYNC: if (hs) begin
        state_n = LEN;
        odata_n = 8'(cnt);
      end
      LEN: if (hs) begin
        state_n = PAYLOAD;
        odata_n = mem[0];
      end
      PAYLOAD: if (hs) begin
        if (last_rd) begin
`ifdef UART_TX_PKT_CHECKSUM_EN
          // the final payload byte is not yet in acc, so fold it in here
          state_n = CHK;
          odata_n = 8'h00 - (acc + odata);
`else
          state_n = COLLECT;
          odata_n = '0;
          ovalid_n = 1'b0;
          cnt_n = '0;
          rd_ptr_n = '0;
`endif
        end else begin
          rd_ptr_n = rd_ptr + 1'b1;
          odata_n = mem[rd_ptr + 1'b1];
        end
      end
`ifdef UART_TX_PKT_CHECKSUM_EN
      CHK: if (hs) begin
        state_n = COLLECT;
        odata_n = '0;
        ovalid_n = 1'b0;
        cnt_n = '0;
        rd_ptr_n = '0;
      end
`endif
      default: state_n = COLLECT;
    endcase
  end
  always_ff @(posedge clk)
    if (accept) mem[cnt[AW-1:0]] <= bus.in_data;
  always_ff @(posedge clk)
    if (rst) begin
      state <= COLLECT;
      cnt <= '0;
      rd_ptr <= '0;
      odata <= '0;
      ovalid <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rd_ptr <= rd_ptr_n;
      odata <= odata_n;
      ovalid <= ovalid_n;
      trunc_q <= accept && full && !bus.in_last;
    end
  assign bus.in_ready = state == COLLECT;
  assign bus.busy = state != COLLECT;
  assign bus.out_data = odata;
  assign bus.out_valid = ovalid;
  assign bus.trunc = trunc_q;
endmodule
